// File: rtl/ultrasound_ranger.sv
// HC-SR04 ultrasonic ranger as an Avalon-MM slave: trigger generation, echo timing, status/IRQ.
// Define ULTRASOUND_AVG_EN to report the mean of the last four good echo widths instead of the raw width.
module ultrasound_ranger #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int PERIOD_CYCLES  = 3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        feedback_in,
    output logic        trigger_out
);

    localparam logic [23:0] TRIG_LAST    = 24'(TRIG_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] PERIOD_LAST  = 24'(PERIOD_CYCLES - 1);
    localparam logic [23:0] WIDTH_MAX    = 24'hFFFFFF;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLD} state_t;

    state_t      state, state_next;
    logic        sync_1, echo_s, echo_d;
    logic        echo_rise, echo_fall;
    logic [23:0] phase_cnt, period_cnt, width_cnt;
    logic        to_hit, done_timeout;
    logic        cont, irq_en, start_req;
    logic        valid, to_flag, overrun;
    logic [23:0] dist_reg, result_value;
    logic        busy, ctrl_wr, dist_rd;
    logic        unused_wdata;

    assign echo_rise    = echo_s & ~echo_d;
    assign echo_fall    = ~echo_s & echo_d;
    assign busy         = (state != IDLE);
    assign ctrl_wr      = write && (address == 2'd2);
    assign dist_rd      = read && (address == 2'd0);
    assign trigger_out  = (state == TRIG);
    assign irq          = valid & irq_en;
    assign unused_wdata = ^writedata[31:4];

    // Two flops resynchronise the asynchronous echo; the third gives edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            sync_1 <= feedback_in;
            echo_s <= sync_1;
            echo_d <= echo_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Timeout wins over a coincident rising edge so the MEASURE timeout compare can never be skipped.
    always_comb begin
        state_next = state;
        to_hit     = 1'b0;
        case (state)
            IDLE:      if (start_req || cont) state_next = TRIG;
            TRIG:      if (phase_cnt == TRIG_LAST) state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (phase_cnt == TIMEOUT_LAST) begin
                    state_next = DONE;
                    to_hit     = 1'b1;
                end else if (echo_rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_next = DONE;
                end else if (phase_cnt == TIMEOUT_LAST) begin
                    state_next = DONE;
                    to_hit     = 1'b1;
                end
            end
            DONE:      state_next = cont ? HOLD : IDLE;
            HOLD: begin
                if (!cont)                            state_next = IDLE;
                else if (period_cnt == PERIOD_LAST)   state_next = TRIG;
            end
            default:   state_next = IDLE;
        endcase
    end

    // phase_cnt times the trigger pulse, then restarts at trigger fall to time the echo timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt    <= '0;
            period_cnt   <= '0;
            width_cnt    <= '0;
            done_timeout <= 1'b0;
        end else begin
            if (state == TRIG && state_next != TRIG)
                phase_cnt <= '0;
            else if (state == TRIG || state == WAIT_RISE || state == MEASURE)
                phase_cnt <= phase_cnt + 24'd1;
            else
                phase_cnt <= '0;

            if (state_next == TRIG && state != TRIG) period_cnt <= '0;
            else if (state != IDLE)                  period_cnt <= period_cnt + 24'd1;
            else                                     period_cnt <= '0;

            if (state == WAIT_RISE && echo_rise)
                width_cnt <= 24'd1;
            else if (state == MEASURE && echo_s && width_cnt != WIDTH_MAX)
                width_cnt <= width_cnt + 24'd1;

            if (state_next == DONE) done_timeout <= to_hit;
        end
    end

`ifdef ULTRASOUND_AVG_EN
    // The three previous good widths plus the arriving one form the four-entry averaging window.
    logic [23:0] prev [3];
    logic [25:0] avg_sum;
    logic [1:0]  unused_avg;

    assign avg_sum      = 26'(width_cnt) + 26'(prev[0]) + 26'(prev[1]) + 26'(prev[2]);
    assign unused_avg   = avg_sum[1:0];
    assign result_value = done_timeout ? WIDTH_MAX : avg_sum[25:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev[0] <= '0;
            prev[1] <= '0;
            prev[2] <= '0;
        end else if (state == DONE && !done_timeout) begin
            prev[0] <= width_cnt;
            prev[1] <= prev[0];
            prev[2] <= prev[1];
        end
    end
`else
    assign result_value = done_timeout ? WIDTH_MAX : width_cnt;
`endif

    // Result capture in DONE takes priority over CLR and over the DIST read side effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont      <= 1'b0;
            irq_en    <= 1'b0;
            start_req <= 1'b0;
            valid     <= 1'b0;
            to_flag   <= 1'b0;
            overrun   <= 1'b0;
            dist_reg  <= '0;
        end else begin
            start_req <= ctrl_wr && writedata[2];
            if (ctrl_wr) begin
                cont   <= writedata[0];
                irq_en <= writedata[1];
            end
            if (state == DONE) begin
                valid    <= 1'b1;
                to_flag  <= done_timeout;
                overrun  <= overrun | valid;
                dist_reg <= result_value;
            end else if (ctrl_wr && writedata[3]) begin
                valid   <= 1'b0;
                to_flag <= 1'b0;
                overrun <= 1'b0;
            end else if (dist_rd) begin
                valid   <= 1'b0;
                to_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                2'd0:    readdata <= {8'd0, dist_reg};
                2'd1:    readdata <= {28'd0, overrun, busy, to_flag, valid};
                2'd2:    readdata <= {30'd0, irq_en, cont};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasound_ranger.sv
// Directed self-checking bench for ultrasound_ranger with short simulation timing parameters.
// Covers the ULTRASOUND_AVG_EN averaging path when that macro is defined.
`timescale 1ns/1ps
module tb_ultrasound_ranger;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        feedback_in;
    logic        trigger_out;

    int          check_count = 0;
    int          pass_count  = 0;
    time         rise_times[$];
    logic [31:0] rd;
    int          base;
    int          cnt;

    ultrasound_ranger #(
        .TRIG_CYCLES(10),
        .TIMEOUT_CYCLES(200),
        .PERIOD_CYCLES(400)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .feedback_in(feedback_in),
        .trigger_out(trigger_out)
    );

    always #5 clk = ~clk;

    always @(posedge trigger_out) rise_times.push_back($time);

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic check_range(input string tag, input logic [31:0] observed, input logic [31:0] lo, input logic [31:0] hi);
        check_count++;
        assert (observed >= lo && observed <= hi) pass_count++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = readdata;
    endtask

    task automatic wait_trigger(input logic lvl, input string tag);
        int n = 0;
        while (trigger_out !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'd0, trigger_out}, {31'd0, lvl});
    endtask

    task automatic apply_stimulus(input int width);
        repeat (19) @(negedge clk);
        feedback_in = 1'b1;
        repeat (width) @(negedge clk);
        feedback_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; feedback_in = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_trigger", {31'd0, trigger_out}, 32'd0);
        check_output("reset_irq", {31'd0, irq}, 32'd0);
        check_output("reset_readdata", readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(2'd1, rd); check_output("reset_status", rd, 32'd0);
        bus_read(2'd2, rd); check_output("reset_ctrl", rd, 32'd0);
        bus_read(2'd0, rd); check_output("reset_dist", rd, 32'd0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd); check_output("addr3_reads_zero", rd, 32'd0);
        bus_read(2'd2, rd); check_output("addr3_write_ignored", rd, 32'd0);

        $display("[TB] single shot with 57-cycle echo");
        bus_write(2'd2, 32'h4);
        check_output("start_latency_low", {31'd0, trigger_out}, 32'd0);
        @(negedge clk);
        check_output("start_latency_high", {31'd0, trigger_out}, 32'd1);
        cnt = 0;
        while (trigger_out && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check_output("trigger_width", cnt, 32'd10);
        apply_stimulus(57);
        check_output("irq_disabled", {31'd0, irq}, 32'd0);
        bus_read(2'd1, rd); check_output("status_valid", rd, 32'h1);
        bus_read(2'd0, rd); check_range("dist_57", rd, 32'd56, 32'd58);
        bus_read(2'd1, rd); check_output("status_after_dist_read", rd, 32'h0);

        $display("[TB] single shot with no echo");
        bus_write(2'd2, 32'h4);
        wait_trigger(1'b1, "t2_trigger_rise");
        wait_trigger(1'b0, "t2_trigger_fall");
        repeat (190) @(negedge clk);
        bus_read(2'd1, rd); check_output("status_busy_waiting", rd, 32'h4);
        repeat (20) @(negedge clk);
        bus_read(2'd1, rd); check_output("status_timeout", rd, 32'h3);
        bus_read(2'd0, rd); check_output("dist_timeout", rd, 32'h00FF_FFFF);
        bus_read(2'd1, rd); check_output("status_timeout_cleared", rd, 32'h0);

        $display("[TB] continuous mode with irq");
        base = rise_times.size();
        bus_write(2'd2, 32'h3);
        wait_trigger(1'b1, "cont_rise1");
        wait_trigger(1'b0, "cont_fall1");
        apply_stimulus(30);
        check_output("cont_irq1", {31'd0, irq}, 32'd1);
        bus_read(2'd2, rd); check_output("ctrl_readback", rd, 32'h3);
        bus_read(2'd1, rd); check_output("status_hold", rd, 32'h5);
        wait_trigger(1'b1, "cont_rise2");
        wait_trigger(1'b0, "cont_fall2");
        apply_stimulus(40);
        bus_write(2'd2, 32'h2);
        repeat (2) @(negedge clk);
        bus_read(2'd1, rd); check_output("status_overrun", rd, 32'h9);
        check_output("cont_rise_count", rise_times.size(), base + 2);
        if (rise_times.size() >= base + 2)
            check_output("cont_period", 32'(rise_times[base + 1] - rise_times[base]), 32'd4000);
        check_output("cont_irq2", {31'd0, irq}, 32'd1);
        bus_read(2'd0, rd); check_range("dist_40", rd, 32'd39, 32'd41);
        check_output("irq_cleared", {31'd0, irq}, 32'd0);
        bus_read(2'd1, rd); check_output("status_overrun_kept", rd, 32'h8);
        bus_write(2'd2, 32'h8);
        bus_read(2'd1, rd); check_output("status_clr", rd, 32'h0);

        $display("[TB] start while busy");
        base = rise_times.size();
        bus_write(2'd2, 32'h4);
        wait_trigger(1'b1, "busy_rise");
        wait_trigger(1'b0, "busy_fall");
        bus_write(2'd2, 32'h4);
        repeat (250) @(negedge clk);
        check_output("busy_start_ignored", rise_times.size(), base + 1);
        bus_read(2'd1, rd); check_output("busy_status", rd, 32'h3);
        bus_write(2'd2, 32'h8);

        $display("[TB] reset during trigger pulse");
        bus_write(2'd2, 32'h4);
        wait_trigger(1'b1, "rst_trig_rise");
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_output("reset_drops_trigger", {31'd0, trigger_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset during measurement");
        bus_write(2'd2, 32'h3);
        wait_trigger(1'b1, "rst_m_rise1");
        wait_trigger(1'b0, "rst_m_fall1");
        apply_stimulus(30);
        check_output("rst_m_irq_before", {31'd0, irq}, 32'd1);
        wait_trigger(1'b1, "rst_m_rise2");
        wait_trigger(1'b0, "rst_m_fall2");
        repeat (19) @(negedge clk);
        feedback_in = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_output("rst_m_trigger", {31'd0, trigger_out}, 32'd0);
        check_output("rst_m_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        feedback_in = 1'b0;
        repeat (3) @(negedge clk);
        bus_read(2'd1, rd); check_output("rst_m_status", rd, 32'h0);
        bus_read(2'd2, rd); check_output("rst_m_ctrl", rd, 32'h0);
        bus_read(2'd0, rd); check_output("rst_m_dist", rd, 32'h0);
        base = rise_times.size();
        repeat (450) @(negedge clk);
        check_output("rst_m_stays_idle", rise_times.size(), base);

`ifdef ULTRASOUND_AVG_EN
        $display("[TB] averaging");
        bus_write(2'd2, 32'h4); wait_trigger(1'b1, "avg_r1"); wait_trigger(1'b0, "avg_f1"); apply_stimulus(40);
        bus_read(2'd0, rd); check_output("avg_1", rd, 32'd10);
        bus_write(2'd2, 32'h4); wait_trigger(1'b1, "avg_r2"); wait_trigger(1'b0, "avg_f2"); apply_stimulus(80);
        bus_read(2'd0, rd); check_output("avg_2", rd, 32'd30);
        bus_write(2'd2, 32'h4); wait_trigger(1'b1, "avg_r3"); wait_trigger(1'b0, "avg_f3"); apply_stimulus(120);
        bus_read(2'd0, rd); check_output("avg_3", rd, 32'd60);
        bus_write(2'd2, 32'h4); wait_trigger(1'b1, "avg_r4"); wait_trigger(1'b0, "avg_f4"); apply_stimulus(160);
        bus_read(2'd0, rd); check_output("avg_4", rd, 32'd100);
        bus_write(2'd2, 32'h4); wait_trigger(1'b1, "avg_r5"); wait_trigger(1'b0, "avg_f5");
        repeat (215) @(negedge clk);
        bus_read(2'd0, rd); check_output("avg_timeout", rd, 32'h00FF_FFFF);
        bus_write(2'd2, 32'h4); wait_trigger(1'b1, "avg_r6"); wait_trigger(1'b0, "avg_f6"); apply_stimulus(40);
        bus_read(2'd0, rd); check_output("avg_after_timeout", rd, 32'd100);
`endif

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
